// File: rtl/mux_1bit_pkg.sv
// Shared constants and helpers for the registered 1-bit selector.
package mux_1bit_pkg;

    // Legal range of synchronizer depth; 0 means inputs already live in clk.
    localparam int SYNC_STAGES_MIN = 0;
    localparam int SYNC_STAGES_MAX = 3;

    function automatic bit sync_stages_legal(int n);
        return (n >= SYNC_STAGES_MIN) && (n <= SYNC_STAGES_MAX);
    endfunction

    // 2:1 select: d1 when sel is high, d0 otherwise.
    function automatic logic sel_bit(logic sel, logic d1, logic d0);
        return sel ? d1 : d0;
    endfunction

endpackage

// File: rtl/mux_1bit_if.sv
// Bit-level bundle between a source of a/b/x and the selector returning y.
interface mux_1bit_if;
    logic a;
    logic b;
    logic x;
    logic y;

    modport master (output a, output b, output x, input y);
    modport slave  (input a, input b, input x, output y);
endinterface

// File: rtl/mux_1bit_sync_bit.sv
// Single-bit synchronizer chain of SYNC_STAGES flops; a plain wire at depth 0.
module mux_1bit_sync_bit
    import mux_1bit_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_depth
        $error("mux_1bit_sync_bit: SYNC_STAGES=%0d outside legal range %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end else if (SYNC_STAGES == 0) begin : g_wire
        // Clock and reset are irrelevant when the input is already synchronous.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_chain
        logic [SYNC_STAGES-1:0] chain_d;
        logic [SYNC_STAGES-1:0] chain_q;

        // Shift the input one stage deeper each cycle.
        always_comb begin
            chain_d[0] = d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_d[i] = chain_q[i-1];
            end
        end

        // Chain flops; reset discards any in-flight samples.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q <= {SYNC_STAGES{RESET_VAL}};
            end else begin
                chain_q <= chain_d;
            end
        end

        assign q = chain_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/mux_1bit.sv
// Registered 1-bit 2:1 selector with independently synchronized inputs.
// y = a when x = 1, else b; each input passes its own synchronizer, so a
// change of x together with the selected data may show one mixed cycle.
module mux_1bit
    import mux_1bit_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_1bit_if.slave   bus
);

    if (!sync_stages_legal(SYNC_STAGES)) begin : g_bad_depth
        $error("mux_1bit: SYNC_STAGES=%0d outside legal range %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    logic a_s;
    logic b_s;
    logic x_s;
    logic y_d;
    logic y_q;

    mux_1bit_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync_a (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.a),
        .q     (a_s)
    );

    mux_1bit_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync_b (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.b),
        .q     (b_s)
    );

    mux_1bit_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(RESET_VAL)) u_sync_x (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.x),
        .q     (x_s)
    );

    // Select between the synchronized sources.
    always_comb begin
        y_d = sel_bit(x_s, a_s, b_s);
    end

    // Output flop keeps y free of any combinational path from the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= RESET_VAL;
        end else begin
            y_q <= y_d;
        end
    end

    assign bus.y = y_q;

endmodule

// File: tb/tb_mux_1bit.sv
// Self-checking bench for mux_1bit: depth-2 (main), depth-0 and depth-3
// (reset value 1) instances share the same stimulus.
`timescale 1ns/1ps
module tb_mux_1bit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic a     = 1'b0;
    logic b     = 1'b0;
    logic x     = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #50 clk = ~clk;

    mux_1bit_if if2 ();
    mux_1bit_if if0 ();
    mux_1bit_if if3 ();

    assign if2.a = a;  assign if2.b = b;  assign if2.x = x;
    assign if0.a = a;  assign if0.b = b;  assign if0.x = x;
    assign if3.a = a;  assign if3.b = b;  assign if3.x = x;

    mux_1bit #(.SYNC_STAGES(2), .RESET_VAL(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mux_1bit #(.SYNC_STAGES(0), .RESET_VAL(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mux_1bit #(.SYNC_STAGES(3), .RESET_VAL(1'b1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // Reference: record the {a,b,x} seen at each rising edge since reset.
    // After an edge, y equals the mux of the sample taken SYNC_STAGES edges
    // earlier, or the reset value if too few edges have passed since release.
    logic [2:0] hist [0:3];
    int         n_since = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_since <= 0;
        end else begin
            hist[0] <= {a, b, x};
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            n_since <= n_since + 1;
        end
    end

    function automatic logic model_y(int ss, logic rv);
        logic [2:0] s;
        if (n_since > ss) begin
            s = hist[ss];
            return s[0] ? s[2] : s[1];
        end
        return rv;
    endfunction

    task automatic chk(string tag, logic obs, logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: y=%b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, "/ss2"}, if2.y, model_y(2, 1'b0));
        chk({tag, "/ss0"}, if0.y, model_y(0, 1'b0));
        chk({tag, "/ss3"}, if3.y, model_y(3, 1'b1));
    endtask

    task automatic chk_in_reset(string tag);
        chk({tag, "/ss2"}, if2.y, 1'b0);
        chk({tag, "/ss0"}, if0.y, 1'b0);
        chk({tag, "/ss3"}, if3.y, 1'b1);
    endtask

    // Basic select table: {a, b, x, expected y}
    logic [3:0] basic_vec [0:5] = '{4'b1011, 4'b0101, 4'b0110, 4'b0010, 4'b1111, 4'b0101};

    initial begin
        // Reset hold with all inputs high.
        #10;
        rst_n = 1'b0;
        a = 1'b1; b = 1'b1; x = 1'b1;
        #1;
        chk_in_reset("rst_async");
        repeat (5) begin
            @(negedge clk);
            chk_in_reset("rst_hold");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_e1/ss2", if2.y, 1'b0);
        chk("rel_e1/ss0", if0.y, 1'b1);
        @(negedge clk);
        chk("rel_e2/ss2", if2.y, 1'b0);
        @(negedge clk);
        chk("rel_e3/ss2", if2.y, 1'b1);
        chk_model("rel");

        // Basic select sequence.
        for (int i = 0; i < 6; i++) begin
            logic [3:0] v;
            v = basic_vec[i];
            @(negedge clk);
            {a, b, x} = v[3:1];
            repeat (3) @(negedge clk);
            chk("basic", if2.y, v[0]);
            chk_model("basic");
        end

        // Unselected isolation: toggle b while a is selected.
        @(negedge clk);
        x = 1'b1; a = 1'b1; b = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("iso_b", if2.y, 1'b1);
            b = ~b;
        end
        // Then toggle a while b is selected.
        x = 1'b0; b = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("iso_a", if2.y, 1'b0);
            chk_model("iso_a");
            a = ~a;
        end

        // Latency: step b 0->1 just before edge n.
        x = 1'b0; b = 1'b0;
        repeat (4) @(negedge clk);
        b = 1'b1;
        @(negedge clk);
        chk("lat_n/ss2", if2.y, 1'b0);
        chk("lat_n/ss0", if0.y, 1'b1);
        @(negedge clk);
        chk("lat_n1/ss2", if2.y, 1'b0);
        @(negedge clk);
        chk("lat_n2/ss2", if2.y, 1'b1);
        chk("lat_n2/ss3", if3.y, 1'b0);
        @(negedge clk);
        chk("lat_n3/ss3", if3.y, 1'b1);

        // Mid-run reset pulse of 30 ns between edges.
        a = 1'b1; x = 1'b1; b = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_pre", if2.y, 1'b1);
        #10 rst_n = 1'b0;
        #1;
        chk_in_reset("mid_async");
        #29 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_e1", if2.y, 1'b0);
        @(negedge clk);
        chk("mid_e2", if2.y, 1'b0);
        @(negedge clk);
        chk("mid_e3", if2.y, 1'b1);
        chk_model("mid");

        // Select switching every 4 cycles.
        a = 1'b1; b = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk_model("switch");
            if (i % 4 == 0) x = ~x;
        end

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            chk_model("rand");
            {a, b, x} = 3'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                #10 rst_n = 1'b0;
                #1;
                chk_in_reset("rand_rst");
                #29 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
